// File: rtl/xbtnsw.sv
// xbtnsw -- debounced push button and slide-switch CPU peripheral.
//
// Btn3 (active-high push button) and Sw[7:0] (slide switches) are
// synchronized with two flops each. The synchronized button is debounced by
// a four-state FSM that needs DEB_CYCLES consecutive stable cycles before it
// accepts a level change. Each accepted press sets a sticky press_flag and
// bumps an 8-bit wrapping press_cnt. The CPU clears both with a write to
// STATUS.
//
// Register map (addr):
//   0 SW     : [7:0] synchronized Sw, remaining bits 0 (read-only)
//   1 STATUS : [0] press_flag, [1] btn_level, [15:8] press_cnt, rest 0
//              any write clears press_flag and press_cnt
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   rst       synchronous active-high reset
//   sel       peripheral select, an access happens in a cycle with sel=1
//   we        write enable, qualified by sel
//   addr      register select (0 = SW, 1 = STATUS)
//   data_in   CPU write data, only the strobe matters
//   data_out  registered read data, loaded on reads and held otherwise
//   Btn3      raw asynchronous push button
//   Sw        raw asynchronous slide switches
//   irq       (only with XBTNSW_IRQ_EN) registered copy of press_flag
//
// Build option: define XBTNSW_IRQ_EN to add the irq output.
// The bus width comes from the `DATA_W macro, which defaults to 32.

`ifndef DATA_W
`define DATA_W 32
`endif

module xbtnsw #(
  parameter int DEB_CYCLES = 1000000,
  parameter int DEB_W      = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel,
  input  logic               we,
  input  logic               addr,
  input  logic [`DATA_W-1:0] data_in,
  output logic [`DATA_W-1:0] data_out,
  input  logic               Btn3,
  input  logic [7:0]         Sw
`ifdef XBTNSW_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam int DATA_W = `DATA_W;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

  generate
    if (DEB_CYCLES < 2 || (64'd1 << DEB_W) <= 64'(DEB_CYCLES)) begin : g_bad_deb
      $error("xbtnsw: need DEB_CYCLES >= 2 and 2**DEB_W > DEB_CYCLES");
    end
    if (DATA_W < 16) begin : g_bad_width
      $error("xbtnsw: DATA_W must be at least 16 to hold STATUS");
    end
  endgenerate

  typedef enum logic [1:0] {
    UP      = 2'd0,
    WAIT_DN = 2'd1,
    DOWN    = 2'd2,
    WAIT_UP = 2'd3
  } btn_state_t;

  logic              btn_p0, btn_p1;
  logic [7:0]        sw_p0, sw_p1;

  btn_state_t        state_q, state_d;
  logic [DEB_W-1:0]  cnt_q, cnt_d;
  logic              press;
  logic              btn_level;

  logic              clr;
  logic              flag_q, flag_d;
  logic [7:0]        pcnt_q, pcnt_d;

  logic              rd_en;
  logic [DATA_W-1:0] rd_data;

  // Write data is a don't-care; only the access strobe matters.
  logic unused_data;
  assign unused_data = ^data_in;

  // ---- stage p0/p1: two-flop synchronizers for the raw inputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
      sw_p0  <= '0;
      sw_p1  <= '0;
    end else begin
      btn_p0 <= Btn3;
      btn_p1 <= btn_p0;
      sw_p0  <= Sw;
      sw_p1  <= sw_p0;
    end
  end

  // ---- debounce FSM on the synchronized button ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press   = 1'b0;
    unique case (state_q)
      UP: begin
        if (btn_p1) begin
          state_d = WAIT_DN;
          cnt_d   = '0;
        end
      end
      WAIT_DN: begin
        if (!btn_p1) begin
          state_d = UP;
        end else if (cnt_q == DEB_LAST) begin
          // Stable for DEB_CYCLES cycles: this is the one accepted press.
          state_d = DOWN;
          press   = 1'b1;
        end else begin
          cnt_d = cnt_q + DEB_ONE;
        end
      end
      DOWN: begin
        if (!btn_p1) begin
          state_d = WAIT_UP;
          cnt_d   = '0;
        end
      end
      WAIT_UP: begin
        if (btn_p1) begin
          state_d = DOWN;
        end else if (cnt_q == DEB_LAST) begin
          state_d = UP;
        end else begin
          cnt_d = cnt_q + DEB_ONE;
        end
      end
      default: begin
        state_d = UP;
        cnt_d   = '0;
      end
    endcase
  end

  // The button still reads as pressed while a release is being debounced.
  assign btn_level = (state_q == DOWN) || (state_q == WAIT_UP);

  // ---- press flag and counter ----
  assign clr = sel && we && addr;

  // A press landing in the same cycle as a clear wins over the clear, so
  // the clear never swallows a press: the result is flag=1, count=1.
  always_comb begin
    flag_d = flag_q;
    pcnt_d = pcnt_q;
    if (press) begin
      flag_d = 1'b1;
      pcnt_d = clr ? 8'd1 : pcnt_q + 8'd1;
    end else if (clr) begin
      flag_d = 1'b0;
      pcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= 1'b0;
      pcnt_q <= '0;
    end else begin
      flag_q <= flag_d;
      pcnt_q <= pcnt_d;
    end
  end

  // ---- read path: one-cycle registered read, held between reads ----
  assign rd_en = sel && !we;

  // Reads sample current state, so a read followed by a clear returns the
  // pre-clear values.
  always_comb begin
    rd_data = '0;
    if (!addr) begin
      rd_data[7:0] = sw_p1;
    end else begin
      rd_data[0]    = flag_q;
      rd_data[1]    = btn_level;
      rd_data[15:8] = pcnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
    end else if (rd_en) begin
      data_out <= rd_data;
    end
  end

`ifdef XBTNSW_IRQ_EN
  // Loaded with the same next value as press_flag so the two always agree.
  logic irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= flag_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_xbtnsw.sv
`ifndef DATA_W
`define DATA_W 32
`endif

module tb_xbtnsw;

  localparam int DEB_CYCLES = 4;
  localparam int DEB_W      = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               sel;
  logic               we;
  logic               addr;
  logic [`DATA_W-1:0] data_in;
  logic [`DATA_W-1:0] data_out;
  logic               Btn3;
  logic [7:0]         Sw;
`ifdef XBTNSW_IRQ_EN
  logic               irq;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  rd_exp_t sb_e;

  // Reference model of the STATUS register.
  logic [7:0] m_cnt   = 8'd0;
  logic       m_flag  = 1'b0;
  logic       m_level = 1'b0;

  always #5 clk = ~clk;

  xbtnsw #(
    .DEB_CYCLES(DEB_CYCLES),
    .DEB_W     (DEB_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .we      (we),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .Btn3    (Btn3),
    .Sw      (Sw)
`ifdef XBTNSW_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  function automatic logic [31:0] stat();
    return {16'h0000, m_cnt, 6'b000000, m_level, m_flag};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one read cycle and queue the value it must return.
  task automatic rd(input logic a, input string nm, input logic [31:0] e);
    rd_exp_t item;
    item.name = nm;
    item.exp  = e;
    sb_q.push_back(item);
    sel  = 1'b1;
    we   = 1'b0;
    addr = a;
    tick(1);
    sel  = 1'b0;
  endtask

  task automatic wr(input logic a);
    sel     = 1'b1;
    we      = 1'b1;
    addr    = a;
    data_in = '1;
    tick(1);
    sel     = 1'b0;
    we      = 1'b0;
    data_in = '0;
    if (a) begin
      m_cnt  = 8'd0;
      m_flag = 1'b0;
    end
  endtask

  task automatic press_release();
    Btn3 = 1'b1;
    tick(8);
    Btn3 = 1'b0;
    tick(8);
    m_cnt  = m_cnt + 8'd1;
    m_flag = 1'b1;
  endtask

  // Scoreboard: every completed read pops one expectation.
  always @(posedge clk) begin
    if (sel === 1'b1 && we === 1'b0 && rst === 1'b0) begin
      #1;
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: read completed with data_out=%h but no expectation queued", data_out);
      end else begin
        sb_e = sb_q.pop_front();
        if (data_out !== `DATA_W'(sb_e.exp)) begin
          n_fail++;
          $display("FAIL %s: data_out=%h expected %h", sb_e.name, data_out, sb_e.exp);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    n_tests++;
    if (data_out !== '0) begin
      n_fail++;
      $display("FAIL reset_data_out: data_out=%h expected 0", data_out);
    end
    rd(1'b1, "reset_status", 32'h0);
  endtask

  task automatic test_sw();
    Sw = 8'h0A;
    tick(3);
    rd(1'b0, "sw_0A", 32'h0000_000A);
    Sw = 8'h0B;
    tick(3);
    rd(1'b0, "sw_0B", 32'h0000_000B);
    Sw = 8'hFF;
    tick(3);
    rd(1'b0, "sw_FF", 32'h0000_00FF);
  endtask

  task automatic test_glitch();
    Btn3 = 1'b1;
    tick(2);
    Btn3 = 1'b0;
    tick(10);
    rd(1'b1, "glitch_status", 32'h0);
  endtask

  task automatic test_press();
    Btn3 = 1'b1;
    tick(10);
    m_cnt   = m_cnt + 8'd1;
    m_flag  = 1'b1;
    m_level = 1'b1;
    rd(1'b1, "press_status", stat());
`ifdef XBTNSW_IRQ_EN
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL press_irq: irq=%b expected 1", irq);
    end
`endif
    Btn3 = 1'b0;
    tick(10);
    m_level = 1'b0;
    rd(1'b1, "release_status", stat());
  endtask

  task automatic test_back_to_back();
    rd(1'b1, "reread_1", stat());
    rd(1'b1, "reread_2", stat());
    rd(1'b0, "b2b_sw", 32'h0000_00FF);
    rd(1'b1, "b2b_status", stat());
  endtask

  task automatic test_read_then_clear();
    logic [31:0] held;
    held = stat();
    rd(1'b1, "pre_clear", held);
    wr(1'b1);
    n_tests++;
    if (data_out !== `DATA_W'(held)) begin
      n_fail++;
      $display("FAIL clear_hold: data_out=%h expected %h", data_out, held);
    end
    rd(1'b1, "post_clear", stat());
`ifdef XBTNSW_IRQ_EN
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_irq: irq=%b expected 0", irq);
    end
`endif
  endtask

  task automatic test_wr_addr0();
    press_release();
    wr(1'b0);
    rd(1'b1, "wr_addr0", stat());
  endtask

  task automatic test_wrap();
    wr(1'b1);
    for (int i = 0; i < 255; i++) press_release();
    rd(1'b1, "cnt_255", stat());
    press_release();
    rd(1'b1, "cnt_wrap", stat());
  endtask

  task automatic test_clear_press_same_cycle();
    press_release();
    press_release();
    Btn3 = 1'b1;
    tick(6);
    // The next edge is the one where the FSM enters DOWN.
    sel     = 1'b1;
    we      = 1'b1;
    addr    = 1'b1;
    data_in = '1;
    tick(1);
    sel     = 1'b0;
    we      = 1'b0;
    data_in = '0;
    m_cnt   = 8'd1;
    m_flag  = 1'b1;
    m_level = 1'b1;
    tick(2);
    rd(1'b1, "clear_press_same", stat());
    Btn3 = 1'b0;
    tick(8);
    m_level = 1'b0;
  endtask

  task automatic test_reset_mid_debounce();
    Btn3 = 1'b1;
    tick(5);
    // Reset coincides with a read; the reset must win.
    rst  = 1'b1;
    sel  = 1'b1;
    we   = 1'b0;
    addr = 1'b1;
    tick(1);
    rst  = 1'b0;
    sel  = 1'b0;
    m_cnt   = 8'd0;
    m_flag  = 1'b0;
    m_level = 1'b0;
    n_tests++;
    if (data_out !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_data_out: data_out=%h expected 0", data_out);
    end
    rd(1'b1, "rst_mid_status", stat());
    tick(8);
    m_cnt   = 8'd1;
    m_flag  = 1'b1;
    m_level = 1'b1;
    rd(1'b1, "rst_redebounce", stat());
    Btn3 = 1'b0;
    tick(8);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    sel     = 1'b0;
    we      = 1'b0;
    addr    = 1'b0;
    data_in = '0;
    Btn3    = 1'b0;
    Sw      = 8'h00;

    test_reset();
    test_sw();
    test_glitch();
    test_press();
    test_back_to_back();
    test_read_then_clear();
    test_wr_addr0();
    test_wrap();
    test_clear_press_same_cycle();
    test_reset_mid_debounce();

    tick(2);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d reads pending expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
